// File: rtl/frb_pkg.sv
// Shared definitions for the FRB threshold trigger.
package frb_pkg;

  typedef enum logic [1:0] {
    ST_WARMUP  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  // One extra bit so the power-minus-baseline difference never overflows.
  function automatic int unsigned diff_width(input int unsigned din_width);
    return din_width + 1;
  endfunction

endpackage

// File: rtl/frb_ema_baseline.sv
// Running baseline: seeded by a block average during warm-up, then tracked with an EMA.
module ema_baseline
  import frb_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = 32,
  parameter int unsigned AVG_LOG2  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic [DIN_WIDTH-1:0] din,
  input  logic                 freeze,
  output logic [DIN_WIDTH-1:0] base,
  output logic                 seeded,
  output logic                 seed_last
);

  localparam int unsigned DW    = diff_width(DIN_WIDTH);
  localparam int unsigned SW    = DIN_WIDTH + AVG_LOG2;
  localparam int unsigned CW    = AVG_LOG2 + 1;
  localparam int unsigned WarmN = 1 << AVG_LOG2;

  logic [DIN_WIDTH-1:0] base_q, base_d;
  logic [SW-1:0]        sum_q, sum_d, sum_next;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 seeded_q, seeded_d;
  logic signed [DW-1:0] diff, step;
  logic [DIN_WIDTH-1:0] ema_next;

  assign sum_next  = sum_q + SW'(din);
  assign seed_last = !seeded_q && (cnt_q == CW'(WarmN - 1));

  // Arithmetic shift floors toward -inf; lower bits of the sum are exact mod 2^DIN_WIDTH.
  assign diff     = $signed({1'b0, din}) - $signed({1'b0, base_q});
  assign step     = diff >>> AVG_LOG2;
  assign ema_next = DIN_WIDTH'($unsigned({1'b0, base_q}) + $unsigned(step));

  always_comb begin
    base_d   = base_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    seeded_d = seeded_q;
    if (sample && !seeded_q) begin
      if (seed_last) begin
        base_d   = DIN_WIDTH'(sum_next >> AVG_LOG2);
        sum_d    = '0;
        cnt_d    = '0;
        seeded_d = 1'b1;
      end else begin
        sum_d = sum_next;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (sample && !freeze) begin
      base_d = ema_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      seeded_q <= 1'b0;
    end else begin
      base_q   <= base_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      seeded_q <= seeded_d;
    end
  end

  assign base   = base_q;
  assign seeded = seeded_q;

endmodule

// File: rtl/frb_trigger.sv
// Threshold trigger: fires when integrated power exceeds baseline plus offset, then holds off.
module frb_trigger
  import frb_pkg::*;
#(
  parameter int unsigned DIN_WIDTH = 32,
  parameter int unsigned AVG_LOG2  = 4,
  parameter int unsigned HOLDOFF   = 64,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic [DIN_WIDTH-1:0] integ_pow,
  input  logic                 integ_valid,
  input  logic [DIN_WIDTH-1:0] thresh_offset,
  input  logic                 thresh_en,
  output logic                 trigger,
  output logic [DIN_WIDTH-1:0] trig_pow,
  output logic [DIN_WIDTH-1:0] trig_base,
  output logic [CNT_WIDTH-1:0] trig_count,
  output logic [1:0]           state
);

  localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  state_t               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 trigger_q, trigger_d;
  logic [DIN_WIDTH-1:0] trig_pow_q, trig_pow_d, trig_base_q, trig_base_d;
  logic [CNT_WIDTH-1:0] trig_count_q, trig_count_d;

  logic                 sample, fire, freeze, seeded, seed_last;
  logic [DIN_WIDTH-1:0] base;
  logic [DIN_WIDTH:0]   lim;

  assign sample = ce && integ_valid;
  // Limit is one bit wider so a huge offset cannot wrap into a low threshold.
  assign lim    = {1'b0, base} + {1'b0, thresh_offset};
  assign fire   = sample && (state_q == ST_ARMED) && thresh_en && ({1'b0, integ_pow} > lim);
  assign freeze = (state_q != ST_ARMED) || fire;

  ema_baseline #(
    .DIN_WIDTH(DIN_WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_ema (
    .clk      (clk),
    .rst      (rst),
    .sample   (sample),
    .din      (integ_pow),
    .freeze   (freeze),
    .base     (base),
    .seeded   (seeded),
    .seed_last(seed_last)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    trigger_d    = 1'b0;
    trig_pow_d   = trig_pow_q;
    trig_base_d  = trig_base_q;
    trig_count_d = trig_count_q;
    unique case (state_q)
      ST_WARMUP: begin
        if (sample && seed_last) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (fire) begin
          trigger_d   = 1'b1;
          trig_pow_d  = integ_pow;
          trig_base_d = base;
          if (trig_count_q != '1) trig_count_d = trig_count_q + 1'b1;
          hold_d  = '0;
          state_d = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (sample) begin
          if (hold_q == HW'(HOLDOFF - 1)) begin
            hold_d  = '0;
            state_d = ST_ARMED;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      default: state_d = ST_WARMUP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_WARMUP;
      hold_q       <= '0;
      trigger_q    <= 1'b0;
      trig_pow_q   <= '0;
      trig_base_q  <= '0;
      trig_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      trigger_q    <= trigger_d;
      trig_pow_q   <= trig_pow_d;
      trig_base_q  <= trig_base_d;
      trig_count_q <= trig_count_d;
    end
  end

  // seeded is only consumed through seed_last; kept visible for readout/debug.
  logic unused_seeded;
  assign unused_seeded = seeded;

  assign trigger    = trigger_q;
  assign trig_pow   = trig_pow_q;
  assign trig_base  = trig_base_q;
  assign trig_count = trig_count_q;
  assign state      = state_q;

endmodule

// File: tb/tb_frb_trigger.sv
// Scoreboard bench for frb_trigger against a behavioural model of the trigger rules.
module tb_frb_trigger;

  localparam int DW = 32;
  localparam int AL = 2;
  localparam int HO = 3;
  localparam int CW = 4;
  localparam longint DIV = longint'(1) << AL;
  localparam longint CMAX = (longint'(1) << CW) - 1;

  logic          clk, rst, ce, integ_valid, thresh_en;
  logic [DW-1:0] integ_pow, thresh_offset;
  logic          trigger;
  logic [DW-1:0] trig_pow, trig_base;
  logic [CW-1:0] trig_count;
  logic [1:0]    state;

  frb_trigger #(
    .DIN_WIDTH(DW),
    .AVG_LOG2 (AL),
    .HOLDOFF  (HO),
    .CNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ce           (ce),
    .integ_pow    (integ_pow),
    .integ_valid  (integ_valid),
    .thresh_offset(thresh_offset),
    .thresh_en    (thresh_en),
    .trigger      (trigger),
    .trig_pow     (trig_pow),
    .trig_base    (trig_base),
    .trig_count   (trig_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit     trig;
    int     st;
    longint base;
    longint tp;
    longint tb;
    longint cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int     m_state, m_wcnt, m_hcnt;
  longint m_base, m_sum, m_tp, m_tb, m_cnt;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_wcnt = 0; m_hcnt = 0;
    m_base = 0; m_sum = 0; m_tp = 0; m_tb = 0; m_cnt = 0;
  endtask

  task automatic model_sample(input longint x, input longint off, input bit en);
    exp_t e;
    longint d, stp;
    e.trig = 1'b0;
    case (m_state)
      0: begin
        m_sum += x;
        m_wcnt++;
        if (m_wcnt == DIV) begin
          m_base = m_sum / DIV;
          m_sum = 0; m_wcnt = 0; m_state = 1;
        end
      end
      1: begin
        if (en && x > m_base + off) begin
          e.trig = 1'b1;
          m_tp = x; m_tb = m_base;
          if (m_cnt < CMAX) m_cnt++;
          m_hcnt = 0; m_state = 2;
        end else begin
          d = x - m_base;
          stp = (d >= 0) ? d / DIV : -((-d + DIV - 1) / DIV);
          m_base += stp;
        end
      end
      default: begin
        m_hcnt++;
        if (m_hcnt == HO) m_state = 1;
      end
    endcase
    e.st = m_state; e.base = m_base; e.tp = m_tp; e.tb = m_tb; e.cnt = m_cnt;
    q.push_back(e);
  endtask

  task automatic send(input longint x, input longint off, input bit en, input bit c);
    @(negedge clk);
    integ_pow = x[DW-1:0];
    thresh_offset = off[DW-1:0];
    thresh_en = en;
    ce = c;
    integ_valid = 1'b1;
    if (c) model_sample(x, off, en);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      integ_valid = 1'b0;
      ce = 1'b1;
    end
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    integ_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_trigger", longint'(trigger), 0);
    chk("rst_trig_pow", longint'(trig_pow), 0);
    chk("rst_trig_base", longint'(trig_base), 0);
    chk("rst_trig_count", longint'(trig_count), 0);
    chk("rst_state", longint'(state), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic warm100();
    repeat (4) send(100, 0, 1, 1);
  endtask

  // Monitor: every accepted sample pops one expectation; otherwise trigger must stay low.
  always @(posedge clk) begin
    bit s;
    exp_t e;
    s = ce && integ_valid && !rst;
    #1;
    if (s) begin
      if (q.size() == 0) begin
        chk("queue_underflow", 1, 0);
      end else begin
        e = q.pop_front();
        chk("trigger", longint'(trigger), longint'(e.trig));
        chk("state", longint'(state), longint'(e.st));
        chk("base", longint'(dut.u_ema.base), e.base);
        chk("trig_pow", longint'(trig_pow), e.tp);
        chk("trig_base", longint'(trig_base), e.tb);
        chk("trig_count", longint'(trig_count), e.cnt);
      end
    end else if (!rst) begin
      chk("trigger_idle", longint'(trigger), 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint x, off;
    rst = 1'b1; ce = 1'b1; integ_valid = 1'b0; thresh_en = 1'b1;
    integ_pow = '0; thresh_offset = '0;
    model_reset();
    #1;
    chk("init_state", longint'(state), 0);
    chk("init_trig_count", longint'(trig_count), 0);
    @(negedge clk); rst = 1'b0;

    // Warm-up with an outlier: no trigger while warming
    send(100, 0, 1, 1); send(1000, 0, 1, 1); send(100, 0, 1, 1); send(100, 0, 1, 1);
    idle(2);
    do_reset(); warm100(); idle(1);

    // Threshold boundary
    send(150, 50, 1, 1); idle(1);
    do_reset(); warm100();
    send(151, 50, 1, 1);
    // Holdoff then second trigger
    send(500, 50, 1, 1); send(500, 50, 1, 1); send(500, 50, 1, 1);
    send(500, 50, 1, 1); idle(2);

    // EMA rounding and disabled trigger
    do_reset(); warm100(); send(120, 1000, 1, 1);
    do_reset(); warm100(); send(79, 1000, 1, 1);
    send(1_000_000, 0, 0, 1);
    send(5_000_000, 0, 1, 0);  // dropped: ce low
    idle(2);

    // No wrap on limit
    do_reset(); warm100();
    send(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 1); idle(2);

    // Count saturation
    do_reset(); warm100();
    repeat (17) begin
      send(1_000_000, 0, 1, 1);
      repeat (HO) send(100, 0, 1, 1);
    end
    idle(2);

    // Reset mid-holdoff, then full warm-up required again
    do_reset(); warm100();
    send(1000, 0, 1, 1); send(100, 0, 1, 1);
    do_reset();
    send(1000, 0, 1, 1); send(1000, 0, 1, 1); send(1000, 0, 1, 1);
    send(1000, 0, 1, 1); send(3000, 0, 1, 1); idle(2);

    // Randomized traffic around the baseline
    do_reset();
    for (int i = 0; i < 400; i++) begin
      case ($urandom % 10)
        0: x = longint'($urandom);
        1: x = 64'hFFFF_FFFF;
        default: begin
          x = m_base + longint'($urandom_range(0, 200)) - 100;
          if (x < 0) x = 0;
          if (x > 64'hFFFF_FFFF) x = 64'hFFFF_FFFF;
        end
      endcase
      off = ($urandom % 16 == 0) ? longint'($urandom) : longint'($urandom_range(0, 150));
      send(x, off, ($urandom % 4) != 0, ($urandom % 8) != 0);
      if ($urandom % 3 == 0) idle(1);
    end
    idle(3);
    chk("queue_drained", longint'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
